input_port_ctrl: RTL and testbench
==================================

Name: input_port_ctrl

Overview:
- Producer end of the CPU input interface: turns board switch/button activity into words the CPU reads through a req/ack handshake.
- Each debounced button press captures the low switch bits, zero-extends them and queues them in a small FIFO.
- The CPU pulls words one at a time and stalls in a wait state while the FIFO is empty.
- Sits in the top level between the switch/button debouncers and the CPU input path; status outputs drive LEDs.

Parameters:
DATA_WIDTH, 16, CPU word width; rd_data width
SW_WIDTH, 4, number of switch bits captured per press (SW_WIDTH <= DATA_WIDTH)
DEPTH, 4, FIFO entries; power of two, >= 2
DEPTH_LOG, 2, log2(DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
sw  in  SW_WIDTH  debounced switch values
btn  in  1  debounced push button, level, active-high
clr  in  1  synchronous flush: empties FIFO, clears overflow
rd_req  in  1  CPU read request, level, held until rd_ack seen
rd_data  out  DATA_WIDTH  word delivered to CPU, registered
rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle
count  out  DEPTH_LOG+1  FIFO occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: a press was dropped while full
waiting  out  1  CPU request pending on an empty FIFO (state WAIT)

Behaviour:
Reset (rst_n=0 at a rising edge):
- rd_data=0, rd_ack=0, count=0, empty=1, full=0, overflow=0, waiting=0.
- FIFO pointers = 0; FSM = IDLE.
- btn_q=1, so a button held through reset does not push after release.

Push path:
- btn_q registers btn every cycle.
- Edge: btn=1 && btn_q=0 in cycle n. Writes {zeros, sw} sampled in cycle n; visible in count/empty at n+1.
- Edge while full with no pop in the same cycle: word dropped, overflow<=1 (sticky until clr or reset).
- Edge while full with a pop in the same cycle: push accepted, count stays DEPTH.
- Push and pop in the same cycle: both happen, count unchanged.
- Pointer wrap: modulo DEPTH.

FSM (registered outputs):
- IDLE:
  - rd_req=1 && !empty: pop head into rd_data, -> ACK.
  - rd_req=1 && empty: -> WAIT.
- WAIT: waiting=1.
  - rd_req=0: -> IDLE, abort, no pop.
  - !empty: pop, load rd_data, -> ACK.
- ACK: rd_ack=1 for exactly this cycle; -> RELEASE.
- RELEASE: -> IDLE once rd_req=0. Prevents a held request from consuming a second word.

Timing and data rules:
- Latency: rd_req rising in cycle n with non-empty FIFO gives rd_ack high in cycle n+1.
- No bypass: a push in cycle n into an empty FIFO while in WAIT gives count=1 at n+1, pop at the n+1 edge, rd_ack in cycle n+2.
- rd_data holds its value until the next pop; it is not cleared by clr.
- count = write pointer minus read pointer using DEPTH_LOG+1 bit pointers; full/empty derived combinationally from count.

clr behaviour:
- Pointers reset, count=0, overflow=0.
- clr with a push in the same cycle: clr wins, word discarded, overflow stays 0.
- clr with a pop decision in the same cycle: pop suppressed, FSM stays in its state (IDLE/WAIT).
- ACK/RELEASE in progress complete normally.

Reset mid-handshake: the FSM returns to IDLE at once. The CPU must re-issue the request.

Test Plan:
- Reset with btn=1 held, then release reset -> no push; count=0, empty=1, overflow=0.
- sw=4'hA, press btn; then sw=4'h3, press btn; then rd_req=1 held -> rd_ack pulse one cycle later with rd_data=16'h000A. Drop and reassert rd_req -> rd_data=16'h0003; count=0, empty=1.
- rd_req=1 on empty FIFO -> waiting=1, no ack for 20 cycles. Press btn with sw=4'h7 -> rd_ack exactly two cycles after the push edge, rd_data=16'h0007, waiting=0.
- Five presses with sw=1..5, no reads (DEPTH=4) -> count=4, full=1, overflow=1. Four reads return 1,2,3,4; the fifth press is lost.
- Hold rd_req high for 10 cycles with FIFO containing 2 words -> exactly one rd_ack and count drops by 1 only.
- FIFO holds 2 words and overflow=1; assert clr for one cycle together with a btn edge -> count=0, overflow=0, a subsequent read waits in WAIT; rd_data keeps its old value.

Source files
------------

// File: rtl/input_port_ctrl.sv
// Input port controller: button presses capture switch values into a small FIFO,
// and the CPU drains it one word at a time through a level req / pulse ack handshake.
module input_port_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int SW_WIDTH   = 4,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic                  btn,
    input  logic                  clr,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ack,
    output logic [DEPTH_LOG:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  waiting,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [DEPTH_LOG:0] FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [SW_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG:0]    wr_ptr_q, rd_ptr_q;
    logic                  btn_q;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  push_edge;
    logic                  push;
    logic                  pop;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign push_edge = btn && !btn_q;
    assign push      = push_edge && !clr && (!full || pop);

    assign rd_data   = rd_data_q;
    assign rd_ack    = (state_q == S_ACK);
    assign waiting   = (state_q == S_WAIT);
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    if (empty) begin
                        state_d = S_WAIT;
                    end else if (!clr) begin
                        pop     = 1'b1;
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!rd_req) begin
                    state_d = S_IDLE;
                end else if (!empty && !clr) begin
                    pop     = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!rd_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            btn_q      <= 1'b1;  // a button held through reset must not look like a fresh press
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
            if (clr) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push_edge && full && !pop) begin
                    overflow_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_data_q <= DATA_WIDTH'(mem_q[rd_ptr_q[DEPTH_LOG-1:0]]);
            end
        end
    end

    // Storage needs no reset; when full with a simultaneous pop, the old head is read before being overwritten.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= sw;
        end
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: a queue-based FIFO model predicts read words and status,
// and a monitor compares every rd_ack against the expected queue.
module tb_input_port_ctrl;

    localparam int DW    = 16;
    localparam int SWW   = 4;
    localparam int DEPTH = 4;
    localparam int DLOG  = 2;

    logic            clk;
    logic            rst_n;
    logic [SWW-1:0]  sw;
    logic            btn;
    logic            clr;
    logic            rd_req;
    logic [DW-1:0]   rd_data;
    logic            rd_ack;
    logic [DLOG:0]   count;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            waiting;
    logic [1:0]      dbg_state;

    input_port_ctrl #(
        .DATA_WIDTH(DW), .SW_WIDTH(SWW), .DEPTH(DEPTH), .DEPTH_LOG(DLOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .clr(clr), .rd_req(rd_req),
        .rd_data(rd_data), .rd_ack(rd_ack), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .waiting(waiting), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: words the CPU will receive, in order, plus sticky overflow
    logic [DW-1:0] exp_q[$];
    bit            ovf_m;
    logic [DW-1:0] last_exp;
    logic [DW-1:0] mon_e;
    int            ack_cnt = 0;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rd_ack === 1'b1) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                last_exp = mon_e;
                chk("rd_data", 32'(rd_data), 32'(mon_e));
            end
        end
    end

    task automatic check_status();
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("empty", 32'(empty), 32'(exp_q.size() == 0));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("waiting_idle", 32'(waiting), 32'd0);
    endtask

    // Driver: one button press; returns the cycle in which btn was high
    task automatic press(input logic [SWW-1:0] v, input logic with_clr, output int t);
        @(negedge clk);
        sw = v; btn = 1'b1; clr = with_clr; t = cyc;
        @(posedge clk);
        if (with_clr) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(DW'(v));
        end else begin
            ovf_m = 1'b1;
        end
        @(negedge clk);
        btn = 1'b0; clr = 1'b0;
    endtask

    // Driver: one complete CPU read on a non-empty FIFO
    task automatic read_word();
        int  t0;
        bit  got;
        @(negedge clk);
        rd_req = 1'b1; t0 = cyc; got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_ack) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got) chk("read_latency", 32'(cyc - t0), 32'd1);
        else     chk("read_ack_timeout", 32'd0, 32'd1);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, a0, acks;
        bit got;

        rst_n = 1'b0; btn = 1'b1; sw = '0; clr = 1'b0; rd_req = 1'b0; ovf_m = 1'b0; last_exp = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_ack", 32'(rd_ack), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_waiting", 32'(waiting), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        check_status();

        // Two presses, two reads in order
        press(4'hA, 1'b0, t);
        press(4'h3, 1'b0, t);
        check_status();
        read_word();
        read_word();
        check_status();

        // Read on empty FIFO waits until a press arrives
        @(negedge clk);
        rd_req = 1'b1; acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        chk("wait_no_ack", 32'(acks), 32'd0);
        chk("wait_waiting", 32'(waiting), 32'd1);
        press(4'h7, 1'b0, t);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_ack) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (got) chk("wait_ack_latency", 32'(cyc - t), 32'd2);
        else     chk("wait_ack_timeout", 32'd0, 32'd1);
        chk("wait_cleared", 32'(waiting), 32'd0);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check_status();

        // Overfill: fifth press is dropped and overflow sticks
        for (int v = 1; v <= 5; v++) press(SWW'(v), 1'b0, t);
        @(negedge clk);
        check_status();
        for (int i = 0; i < 4; i++) read_word();
        check_status();

        // Held request consumes exactly one word
        press(4'h8, 1'b0, t);
        press(4'h9, 1'b0, t);
        @(negedge clk);
        rd_req = 1'b1; a0 = ack_cnt;
        repeat (10) @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold_one_ack", 32'(ack_cnt - a0), 32'd1);
        check_status();

        // Press while full with a simultaneous pop is accepted
        for (int v = 0; v < 3; v++) press(SWW'(4'hB + v), 1'b0, t);
        @(negedge clk);
        check_status();
        a0 = ack_cnt;
        rd_req = 1'b1; btn = 1'b1; sw = 4'h6;
        @(posedge clk);
        exp_q.push_back(DW'(4'h6));
        @(negedge clk);
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("full_pop_one_ack", 32'(ack_cnt - a0), 32'd1);
        check_status();

        // Two words left with overflow set, then clr coinciding with a press
        read_word();
        read_word();
        check_status();
        press(4'h5, 1'b1, t);
        @(negedge clk);
        check_status();
        rd_req = 1'b1; acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        chk("clr_waiting", 32'(waiting), 32'd1);
        chk("clr_no_ack", 32'(acks), 32'd0);
        chk("clr_rd_data_hold", 32'(rd_data), 32'(last_exp));
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check_status();

        // Randomized presses, reads and occasional flushes
        for (int it = 0; it < 80; it++) begin
            if (exp_q.size() == 0 || $urandom_range(0, 2) != 0) begin
                press(SWW'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), t);
                @(negedge clk);
            end else begin
                read_word();
            end
            check_status();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
